// File: rtl/luces_pkg.sv
// Shared types and defaults for the light-chaser speed controller.
package luces_pkg;

    typedef enum logic [1:0] {REPOSO, ESPERA, REPETIR, BLOQUEO} estado_t;

    typedef enum logic [1:0] {NADA, SUBIR, BAJAR, INICIAL} accion_t;

    localparam int WIDTH_DEF     = 4;
    localparam int PRESCALER_DEF = 500_000;

endpackage

// File: rtl/control_velocidad_luces_antirrebote.sv
// Two-flop synchronizer plus two-sample debounce for one active-low key.
// Samples only on base ticks; output is active-high "pressed".
module antirrebote (
    input  logic CLK,
    input  logic RSTn,
    input  logic tick,
    input  logic tecla_n,
    output logic pulsada
);

    logic s1, s2, muestra;

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            s1      <= 1'b1;
            s2      <= 1'b1;
            muestra <= 1'b1;
            pulsada <= 1'b0;
        end else begin
            s1 <= tecla_n;
            s2 <= s1;
            if (tick) begin
                muestra <= s2;
                // Two equal consecutive samples change state; a mixed pair holds it.
                if (!s2 && !muestra)
                    pulsada <= 1'b1;
                else if (s2 && muestra)
                    pulsada <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/control_velocidad_luces.sv
// Speed controller: debounced up/down keys with hold-to-repeat drive a
// saturating level, which sets how often the step strobe fires.
module control_velocidad_luces
    import luces_pkg::*;
#(
    parameter int PRESCALER     = PRESCALER_DEF,
    parameter int WIDTH         = WIDTH_DEF,
    parameter int NIVEL_INICIAL = 8,
    parameter int RETARDO_REP   = 50,
    parameter int PERIODO_REP   = 10
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             ENABLE,
    input  logic             KEY_UP,
    input  logic             KEY_DOWN,
    output logic [WIDTH-1:0] NIVEL,
    output logic             PASO,
    output logic             BASE_TICK,
    output logic             LIMITE
);

    localparam int PW      = $clog2(PRESCALER);
    localparam int REP_MAX = (RETARDO_REP > PERIODO_REP) ? RETARDO_REP : PERIODO_REP;
    localparam int RW      = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;

    localparam logic [WIDTH-1:0] NIVEL_MAX = '1;
    localparam logic [WIDTH-1:0] NIVEL_INI = WIDTH'(NIVEL_INICIAL);
    localparam logic [RW-1:0]    CARGA_RET = RW'(RETARDO_REP - 1);
    localparam logic [RW-1:0]    CARGA_PER = RW'(PERIODO_REP - 1);

    logic [PW-1:0]    pre_cnt;
    logic [WIDTH-1:0] div_cnt;
    logic [WIDTH-1:0] umbral;
    logic [RW-1:0]    rep_cnt, rep_sig;
    logic [WIDTH-1:0] nivel_sig;
    logic             up, down;
    logic             dir, dir_sig;
    logic             tecla_act, tecla_otra;
    estado_t          estado, estado_sig;
    accion_t          accion;

    antirrebote u_ar_up (
        .CLK     (CLK),
        .RSTn    (RSTn),
        .tick    (BASE_TICK),
        .tecla_n (KEY_UP),
        .pulsada (up)
    );

    antirrebote u_ar_down (
        .CLK     (CLK),
        .RSTn    (RSTn),
        .tick    (BASE_TICK),
        .tecla_n (KEY_DOWN),
        .pulsada (down)
    );

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            pre_cnt   <= '0;
            BASE_TICK <= 1'b0;
        end else if (pre_cnt == PW'(PRESCALER - 1)) begin
            pre_cnt   <= '0;
            BASE_TICK <= 1'b1;
        end else begin
            pre_cnt   <= pre_cnt + 1'b1;
            BASE_TICK <= 1'b0;
        end
    end

    // dir remembers which key owns ESPERA/REPETIR (1 = UP).
    assign tecla_act  = dir ? up : down;
    assign tecla_otra = dir ? down : up;

    always_comb begin
        estado_sig = estado;
        rep_sig    = rep_cnt;
        dir_sig    = dir;
        accion     = NADA;
        if (BASE_TICK) begin
            case (estado)
                REPOSO: begin
                    if (up && down) begin
                        accion     = INICIAL;
                        estado_sig = BLOQUEO;
                    end else if (up || down) begin
                        accion     = up ? SUBIR : BAJAR;
                        dir_sig    = up;
                        rep_sig    = CARGA_RET;
                        estado_sig = ESPERA;
                    end
                end
                ESPERA, REPETIR: begin
                    if (!tecla_act) begin
                        estado_sig = REPOSO;
                    end else if (tecla_otra) begin
                        accion     = INICIAL;
                        estado_sig = BLOQUEO;
                    end else if (rep_cnt == '0) begin
                        accion     = dir ? SUBIR : BAJAR;
                        rep_sig    = CARGA_PER;
                        estado_sig = REPETIR;
                    end else begin
                        rep_sig = rep_cnt - 1'b1;
                    end
                end
                BLOQUEO: begin
                    if (!up && !down)
                        estado_sig = REPOSO;
                end
                default: estado_sig = REPOSO;
            endcase
        end
    end

    always_comb begin
        nivel_sig = NIVEL;
        case (accion)
            SUBIR:   if (NIVEL != NIVEL_MAX) nivel_sig = NIVEL + 1'b1;
            BAJAR:   if (NIVEL != '0)        nivel_sig = NIVEL - 1'b1;
            INICIAL: nivel_sig = NIVEL_INI;
            default: nivel_sig = NIVEL;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            estado  <= REPOSO;
            rep_cnt <= '0;
            dir     <= 1'b0;
            NIVEL   <= NIVEL_INI;
        end else begin
            estado  <= estado_sig;
            rep_cnt <= rep_sig;
            dir     <= dir_sig;
            NIVEL   <= nivel_sig;
        end
    end

    // Fires once div_cnt reaches (max - level); >= lets a sudden level rise
    // land on the next tick instead of waiting for a wrap.
    assign umbral = NIVEL_MAX - NIVEL;

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            div_cnt <= '0;
            PASO    <= 1'b0;
        end else if (BASE_TICK && ENABLE) begin
            if (div_cnt >= umbral) begin
                div_cnt <= '0;
                PASO    <= 1'b1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
                PASO    <= 1'b0;
            end
        end else begin
            PASO <= 1'b0;
        end
    end

    assign LIMITE = (NIVEL == '0) || (NIVEL == NIVEL_MAX);

endmodule

// File: tb/tb_control_velocidad_luces.sv
// Directed bench for control_velocidad_luces with a short prescaler.
module tb_control_velocidad_luces;

    logic       CLK = 1'b0;
    logic       RSTn, ENABLE, KEY_UP, KEY_DOWN;
    logic [3:0] NIVEL;
    logic       PASO, BASE_TICK, LIMITE;

    int vectors = 0;
    int miscompares = 0;

    control_velocidad_luces #(
        .PRESCALER     (4),
        .WIDTH         (4),
        .NIVEL_INICIAL (8),
        .RETARDO_REP   (3),
        .PERIODO_REP   (2)
    ) dut (
        .CLK       (CLK),
        .RSTn      (RSTn),
        .ENABLE    (ENABLE),
        .KEY_UP    (KEY_UP),
        .KEY_DOWN  (KEY_DOWN),
        .NIVEL     (NIVEL),
        .PASO      (PASO),
        .BASE_TICK (BASE_TICK),
        .LIMITE    (LIMITE)
    );

    always #5 CLK = ~CLK;

    // The bench always parks on the negedge of a BASE_TICK cycle; ticks keep that alignment.
    task automatic tick(input int n);
        repeat (n * 4) @(negedge CLK);
    endtask

    task automatic tap(input bit up);
        if (up) KEY_UP = 1'b0; else KEY_DOWN = 1'b0;
        tick(3);
        KEY_UP   = 1'b1;
        KEY_DOWN = 1'b1;
        tick(5);
    endtask

    // Cycles between two consecutive PASO pulses; -1 on timeout. Returns on a PASO cycle.
    task automatic measure_paso(output int cyc);
        int n;
        n = 0;
        while (!PASO && n < 200) begin @(negedge CLK); n++; end
        if (!PASO) begin cyc = -1; return; end
        n = 0;
        do begin @(negedge CLK); n++; end while (!PASO && n < 200);
        cyc = PASO ? n : -1;
    endtask

    task automatic test_reset;
        RSTn = 1'b0; ENABLE = 1'b1; KEY_UP = 1'b1; KEY_DOWN = 1'b1;
        repeat (3) @(negedge CLK);
        vectors++;
        if (NIVEL !== 4'd8) begin miscompares++; $display("FAIL reset_nivel: got %0d expected 8", NIVEL); end
        vectors++;
        if (PASO !== 1'b0 || BASE_TICK !== 1'b0) begin
            miscompares++; $display("FAIL reset_strobes: paso=%b tick=%b expected 0 0", PASO, BASE_TICK);
        end
        vectors++;
        if (LIMITE !== 1'b0) begin miscompares++; $display("FAIL reset_limite: got %b expected 0", LIMITE); end
        RSTn = 1'b1;
        for (int k = 1; k <= 72; k++) begin
            @(negedge CLK);
            vectors++;
            if (BASE_TICK !== (k % 4 == 0)) begin
                miscompares++; $display("FAIL base_tick k=%0d: got %b expected %b", k, BASE_TICK, (k % 4 == 0));
            end
            vectors++;
            if (PASO !== (k == 33 || k == 65)) begin
                miscompares++; $display("FAIL paso_lvl8 k=%0d: got %b expected %b", k, PASO, (k == 33 || k == 65));
            end
        end
    endtask

    task automatic test_tap;
        int cyc;
        KEY_UP = 1'b0;
        tick(3);
        vectors++;
        if (NIVEL !== 4'd8) begin miscompares++; $display("FAIL tap_before: got %0d expected 8", NIVEL); end
        KEY_UP = 1'b1;
        tick(1);
        vectors++;
        if (NIVEL !== 4'd9) begin miscompares++; $display("FAIL tap_step: got %0d expected 9", NIVEL); end
        tick(4);
        vectors++;
        if (NIVEL !== 4'd9) begin miscompares++; $display("FAIL tap_once: got %0d expected 9", NIVEL); end
        measure_paso(cyc);
        repeat (3) @(negedge CLK);
        vectors++;
        if (cyc !== 28) begin miscompares++; $display("FAIL paso_period_lvl9: got %0d expected 28", cyc); end
    endtask

    task automatic test_hold_up;
        int cyc;
        repeat (4) tap(1'b1);
        vectors++;
        if (NIVEL !== 4'd13) begin miscompares++; $display("FAIL setup_13: got %0d expected 13", NIVEL); end
        KEY_UP = 1'b0;
        tick(3);
        vectors++;
        if (NIVEL !== 4'd13) begin miscompares++; $display("FAIL hold_t3: got %0d expected 13", NIVEL); end
        tick(1);
        vectors++;
        if (NIVEL !== 4'd14) begin miscompares++; $display("FAIL hold_first: got %0d expected 14", NIVEL); end
        tick(2);
        vectors++;
        if (NIVEL !== 4'd14) begin miscompares++; $display("FAIL hold_delay: got %0d expected 14", NIVEL); end
        tick(1);
        vectors++;
        if (NIVEL !== 4'd15) begin miscompares++; $display("FAIL hold_repeat: got %0d expected 15", NIVEL); end
        tick(10);
        vectors++;
        if (NIVEL !== 4'd15) begin miscompares++; $display("FAIL hold_saturate: got %0d expected 15", NIVEL); end
        vectors++;
        if (LIMITE !== 1'b1) begin miscompares++; $display("FAIL limite_max: got %b expected 1", LIMITE); end
        measure_paso(cyc);
        repeat (3) @(negedge CLK);
        vectors++;
        if (cyc !== 4) begin miscompares++; $display("FAIL paso_period_lvl15: got %0d expected 4", cyc); end
        KEY_UP = 1'b1;
        tick(6);
    endtask

    task automatic test_hold_down;
        int cyc;
        KEY_DOWN = 1'b0;
        tick(20);
        vectors++;
        if (NIVEL !== 4'd7) begin miscompares++; $display("FAIL down_mid: got %0d expected 7", NIVEL); end
        tick(25);
        vectors++;
        if (NIVEL !== 4'd0) begin miscompares++; $display("FAIL down_floor: got %0d expected 0", NIVEL); end
        vectors++;
        if (LIMITE !== 1'b1) begin miscompares++; $display("FAIL limite_min: got %b expected 1", LIMITE); end
        measure_paso(cyc);
        repeat (3) @(negedge CLK);
        vectors++;
        if (cyc !== 64) begin miscompares++; $display("FAIL paso_period_lvl0: got %0d expected 64", cyc); end
        vectors++;
        if (NIVEL !== 4'd0) begin miscompares++; $display("FAIL down_no_wrap: got %0d expected 0", NIVEL); end
        KEY_DOWN = 1'b1;
        tick(6);
    endtask

    task automatic test_both_keys;
        repeat (3) tap(1'b1);
        vectors++;
        if (NIVEL !== 4'd3) begin miscompares++; $display("FAIL setup_3: got %0d expected 3", NIVEL); end
        KEY_UP = 1'b0; KEY_DOWN = 1'b0;
        tick(4);
        vectors++;
        if (NIVEL !== 4'd8) begin miscompares++; $display("FAIL both_init: got %0d expected 8", NIVEL); end
        tick(10);
        vectors++;
        if (NIVEL !== 4'd8) begin miscompares++; $display("FAIL both_held: got %0d expected 8", NIVEL); end
        KEY_DOWN = 1'b1;
        tick(6);
        vectors++;
        if (NIVEL !== 4'd8) begin miscompares++; $display("FAIL both_one_left: got %0d expected 8", NIVEL); end
        KEY_UP = 1'b1;
        tick(6);
        tap(1'b0);
        vectors++;
        if (NIVEL !== 4'd7) begin miscompares++; $display("FAIL after_block: got %0d expected 7", NIVEL); end
    endtask

    task automatic test_enable_and_reset;
        int n;
        n = 0;
        while (!PASO && n < 200) begin @(negedge CLK); n++; end
        vectors++;
        if (PASO !== 1'b1) begin miscompares++; $display("FAIL paso_timeout: got %b expected 1", PASO); end
        repeat (3) @(negedge CLK);
        ENABLE = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge CLK);
            vectors++;
            if (PASO !== 1'b0) begin miscompares++; $display("FAIL paused_paso k=%0d: got %b expected 0", k, PASO); end
        end
        ENABLE = 1'b1;
        n = 0;
        do begin @(negedge CLK); n++; end while (!PASO && n < 200);
        vectors++;
        if (n !== 33) begin miscompares++; $display("FAIL resume_latency: got %0d expected 33", n); end
        repeat (3) @(negedge CLK);
        KEY_UP = 1'b0;
        tick(7);
        RSTn = 1'b0;
        @(negedge CLK);
        vectors++;
        if (NIVEL !== 4'd8) begin miscompares++; $display("FAIL midrep_reset_nivel: got %0d expected 8", NIVEL); end
        vectors++;
        if (PASO !== 1'b0 || BASE_TICK !== 1'b0) begin
            miscompares++; $display("FAIL midrep_reset_strobes: paso=%b tick=%b expected 0 0", PASO, BASE_TICK);
        end
        RSTn = 1'b1;
        repeat (12) @(negedge CLK);
        vectors++;
        if (NIVEL !== 4'd8) begin miscompares++; $display("FAIL repress_before: got %0d expected 8", NIVEL); end
        repeat (4) @(negedge CLK);
        vectors++;
        if (NIVEL !== 4'd9) begin miscompares++; $display("FAIL repress_step: got %0d expected 9", NIVEL); end
        KEY_UP = 1'b1;
        tick(6);
    endtask

    initial begin
        test_reset;
        test_tap;
        test_hold_up;
        test_hold_down;
        test_both_keys;
        test_enable_and_reset;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
